// File: rtl/nmea_rmc_tx.sv
// nmea_rmc_tx: streams one 61-byte $GPRMC sentence, byte by byte, into a UART transmitter handshake.
module nmea_rmc_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [71:0] utc_time,
  input  logic [7:0]  status,
  input  logic [79:0] latitude,
  input  logic [7:0]  ns_flag,
  input  logic [87:0] longitude,
  input  logic [7:0]  ew_flag,
  input  logic [47:0] ddmmyy,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, ACK, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [5:0]   idx;
  logic [7:0]   csum, hi, lo, cur;
  logic [71:0]  t_r;
  logic [79:0]  lat_r;
  logic [87:0]  lon_r;
  logic [47:0]  date_r;
  logic [7:0]   st_r, ns_r, ew_r;
  logic [487:0] line;
  assign hi = csum[7:4] < 4'd10 ? {4'h3, csum[7:4]} : 8'h37 + {4'h0, csum[7:4]};
  assign lo = csum[3:0] < 4'd10 ? {4'h3, csum[3:0]} : 8'h37 + {4'h0, csum[3:0]};
  // Byte 0 sits in the least significant byte so the byte index selects directly
  assign line = {8'h0a, 8'h0d, lo, hi, 8'h2a, 16'h2c2c, date_r, 24'h2c2c2c, ew_r, 8'h2c,
                 lon_r, 8'h2c, ns_r, 8'h2c, lat_r, 8'h2c, st_r, 8'h2c, t_r,
                 56'h2c_43_4d_52_50_47_24};
  assign cur = line[{idx, 3'b000} +: 8];
  assign tx_start = state == ISSUE && !tx_busy;
  assign tx_data = (state == ISSUE || state == ACK || state == DRAIN) ? cur : 8'h00;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = ISSUE;
      ISSUE:   nxt = tx_busy ? ISSUE : ACK;
      ACK:     nxt = tx_busy ? DRAIN : ACK;
      DRAIN:   nxt = tx_busy ? DRAIN : (idx == 6'd60 ? DONE : ISSUE);
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      csum   <= '0;
      t_r    <= '0;
      st_r   <= '0;
      lat_r  <= '0;
      ns_r   <= '0;
      lon_r  <= '0;
      ew_r   <= '0;
      date_r <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        t_r    <= utc_time;
        st_r   <= status;
        lat_r  <= latitude;
        ns_r   <= ns_flag;
        lon_r  <= longitude;
        ew_r   <= ew_flag;
        date_r <= ddmmyy;
      end
      if (state == LOAD) begin
        idx  <= '0;
        csum <= '0;
      end
      if (tx_start && idx != 6'd0 && idx < 6'd56) csum <= csum ^ cur;
      if (state == DRAIN && !tx_busy) idx <= idx + 6'd1;
    end
  end
endmodule

// File: tb/tb_nmea_rmc_tx.sv
// tb_nmea_rmc_tx: scoreboard bench for nmea_rmc_tx with a 10-cycle-busy UART model.
module tb_nmea_rmc_tx;
  logic        clk = 0, rst = 1, start = 0, hold = 0;
  logic [71:0] utc_time;
  logic [7:0]  status, ns_flag, ew_flag;
  logic [79:0] latitude;
  logic [87:0] longitude;
  logic [47:0] ddmmyy;
  logic        tx_busy, tx_start, busy, done;
  logic [7:0]  tx_data;
  int          ucnt = 0;
  int          checks = 0, errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  cap[0:63];
  int          cap_n = 0, done_n = 0;

  nmea_rmc_tx dut (
    .clk(clk), .rst(rst), .start(start), .utc_time(utc_time), .status(status),
    .latitude(latitude), .ns_flag(ns_flag), .longitude(longitude), .ew_flag(ew_flag),
    .ddmmyy(ddmmyy), .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  always @(posedge clk) ucnt <= tx_start ? 10 : (ucnt > 0 ? ucnt - 1 : 0);
  assign tx_busy = (ucnt != 0) | hold;

  always @(negedge clk) begin
    logic [7:0] e;
    if (tx_start) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tx_start got=%h expected=none", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL byte[%0d] got=%h expected=%h", cap_n, tx_data, e);
        end
      end
      if (cap_n < 64) cap[cap_n] = tx_data;
      cap_n++;
    end
    if (done) done_n++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [87:0] rev(input logic [87:0] s, input int n);
    logic [87:0] r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = s[8*(n-1-i) +: 8];
    return r;
  endfunction

  task automatic set_fields(input logic [87:0] t, input logic [87:0] la, input logic [87:0] lo,
                            input logic [47:0] d);
    logic [87:0] r;
    r = rev(t, 9);  utc_time = r[71:0];
    r = rev(la, 10); latitude = r[79:0];
    longitude = rev(lo, 11);
    r = rev({40'h0, d}, 6); ddmmyy = r[47:0];
    status = "A"; ns_flag = "N"; ew_flag = "E";
  endtask

  task automatic push_expected();
    logic [7:0]   q[$];
    logic [7:0]   cs = 0;
    logic [127:0] hx = "0123456789ABCDEF";
    q = {8'h24, 8'h47, 8'h50, 8'h52, 8'h4d, 8'h43, 8'h2c};
    for (int i = 0; i < 9; i++) q.push_back(utc_time[8*i +: 8]);
    q.push_back(","); q.push_back(status); q.push_back(",");
    for (int i = 0; i < 10; i++) q.push_back(latitude[8*i +: 8]);
    q.push_back(","); q.push_back(ns_flag); q.push_back(",");
    for (int i = 0; i < 11; i++) q.push_back(longitude[8*i +: 8]);
    q.push_back(","); q.push_back(ew_flag); q.push_back(","); q.push_back(","); q.push_back(",");
    for (int i = 0; i < 6; i++) q.push_back(ddmmyy[8*i +: 8]);
    q.push_back(","); q.push_back(",");
    for (int i = 1; i < 56; i++) cs ^= q[i];
    q.push_back("*");
    q.push_back(hx[8*(15-int'(cs[7:4])) +: 8]);
    q.push_back(hx[8*(15-int'(cs[3:0])) +: 8]);
    q.push_back(8'h0d); q.push_back(8'h0a);
    foreach (q[i]) exp_q.push_back(q[i]);
  endtask

  task automatic send();
    @(negedge clk);
    push_expected();
    cap_n = 0;
    done_n = 0;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_cap(input int n);
    int k = 0;
    while (cap_n < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_byte_timeout", 32'(k < 2000), 32'd1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_done_timeout", 32'(k < 3000), 32'd1);
    repeat (5) @(negedge clk);
  endtask

  task automatic end_check(input string nm, input logic [7:0] h1, input logic [7:0] h2);
    logic [55:0] hdr = 56'h2c_43_4d_52_50_47_24;
    chk({nm, "_count"}, 32'(cap_n), 32'd61);
    chk({nm, "_done_pulses"}, 32'(done_n), 32'd1);
    chk({nm, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
    for (int i = 0; i < 7; i++) chk({nm, "_hdr"}, 32'(cap[i]), 32'(hdr[8*i +: 8]));
    chk({nm, "_cs_hi"}, 32'(cap[57]), 32'(h1));
    chk({nm, "_cs_lo"}, 32'(cap[58]), 32'(h2));
    chk({nm, "_cr"}, 32'(cap[59]), 32'h0d);
    chk({nm, "_lf"}, 32'(cap[60]), 32'h0a);
  endtask

  initial begin
    int n;
    set_fields(88'("123519.00"), 88'("4807.03800"), 88'("01131.00000"), "230394");
    #1;
    chk("reset_tx_start", 32'(tx_start), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    repeat (3) @(negedge clk);
    rst = 0;
    send();
    wait_done();
    end_check("basic", "3", "3");
    set_fields(88'("123519.09"), 88'("4807.03800"), 88'("01131.00000"), "230394");
    send();
    wait_done();
    end_check("cs3a", "3", "A");
    set_fields(88'("123519.00"), 88'("4807.03800"), 88'("01131.00000"), "230394");
    @(negedge clk);
    hold = 1;
    send();
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_start) n++;
    end
    chk("hold_no_start", 32'(n), 32'd0);
    hold = 0;
    wait_done();
    end_check("hold", "3", "3");
    send();
    wait_cap(10);
    start = 1; @(negedge clk); start = 0;
    wait_cap(40);
    start = 1; @(negedge clk); start = 0;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("restart_done_timeout", 32'(n < 3000), 32'd1);
    start = 1; @(negedge clk); start = 0;
    repeat (30) @(negedge clk);
    end_check("restart", "3", "3");
    send();
    wait_cap(31);
    #2 rst = 1;
    #1;
    chk("midrst_tx_start", 32'(tx_start), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 0;
    n = cap_n;
    repeat (30) @(negedge clk);
    chk("midrst_quiet", 32'(cap_n), 32'(n));
    send();
    wait_done();
    end_check("after_rst", "3", "3");
    send();
    latitude = 80'h39_39_39_39_39_2e_39_39_39_39;
    wait_done();
    end_check("latch", "3", "3");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nmea_rmc_tx.md
NMEA_RMC_TX -- requirements
Module: nmea_rmc_tx

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request to send one sentence.
REQ-004 SHALL have port utc_time, input, 72 bits: 9 ASCII chars "hhmmss.ss".
REQ-005 SHALL have port status, input, 8 bits: ASCII 'A' (0x41) or 'V' (0x56).
REQ-006 SHALL have port latitude, input, 80 bits: 10 ASCII chars "ddmm.mmmmm".
REQ-007 SHALL have port ns_flag, input, 8 bits: ASCII 'N' or 'S'.
REQ-008 SHALL have port longitude, input, 88 bits: 11 ASCII chars "dddmm.mmmmm".
REQ-009 SHALL have port ew_flag, input, 8 bits: ASCII 'E' or 'W'.
REQ-010 SHALL have port ddmmyy, input, 48 bits: 6 ASCII date chars.
REQ-011 SHALL have port tx_busy, input, 1 bit: UART transmitter busy, high while shifting a byte.
REQ-012 SHALL have port tx_data, output, 8 bits: byte handed to the UART transmitter.
REQ-013 SHALL have port tx_start, output, 1 bit: one-cycle strobe qualifying tx_data.
REQ-014 SHALL have port busy, output, 1 bit: high from start acceptance until sentence completion.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse after the last byte completes.
REQ-016 SHALL transmit the first character of each multi-char field from bits [7:0], then the next-higher byte.

Function
REQ-017 SHALL emit the 61-byte sentence "$GPRMC," time "," status "," lat "," ns "," lon "," ew ",,," date ",,*" HH CR LF (byte indices 0..60).
REQ-018 SHALL latch all field inputs on the cycle start is accepted; input changes during a sentence do not affect it.
REQ-019 SHALL accept start only in IDLE; start while busy is ignored.
REQ-020 SHALL implement states IDLE -> LOAD (latch, clear checksum, index=0) -> ISSUE -> ACK -> DRAIN -> (ISSUE, or DONE after index 60) -> IDLE.
REQ-021 SHALL, in ISSUE, wait until tx_busy=0, then drive tx_data and pulse tx_start for exactly one cycle.
REQ-022 SHALL, in ACK, wait for tx_busy=1; in DRAIN, wait for tx_busy=0, then increment the 6-bit byte index.
REQ-023 SHALL hold tx_data stable from the tx_start cycle until DRAIN exits.
REQ-024 SHALL compute the checksum as the 8-bit XOR of bytes 1..55 (after '$', before '*'), updated on each issued byte in that range.
REQ-025 SHALL send the checksum as two uppercase hex ASCII chars, high nibble first (0-9 -> 0x30-0x39, A-F -> 0x41-0x46).
REQ-026 SHALL assert busy from the LOAD cycle through DONE and deassert it in IDLE.
REQ-027 SHALL pulse done in the DONE state; a start arriving in that same cycle is ignored.
REQ-028 SHALL issue exactly 61 tx_start pulses per accepted start, with no gaps skipped and no repeats.

Reset
REQ-029 SHALL force, while rst=1 (asynchronously), state=IDLE, index=0, checksum=0, tx_data=0x00, tx_start=0, busy=0, done=0.
REQ-030 SHALL abandon a sentence in progress when rst is asserted mid-sentence; after release, no tx_start occurs until a new start.

Verification
REQ-031 SHALL pass: fields "123519.00", 'A', "4807.03800", 'N', "01131.00000", 'E', "230394"; UART model with 10-cycle busy -> 61 tx_start pulses; bytes 0..6 = 24 47 50 52 4D 43 2C; bytes 59,60 = 0D 0A; bytes 57,58 = hex of XOR(bytes 1..55) per a software model.
REQ-032 SHALL pass: inputs chosen so the checksum = 0x3A -> bytes 57,58 = 0x33,0x41.
REQ-033 SHALL pass: tx_busy held 1 at start -> no tx_start until tx_busy falls; then the first pulse carries 0x24.
REQ-034 SHALL pass: start pulsed again at bytes 10 and 40, and in the DONE cycle -> ignored, still exactly 61 bytes, one done pulse.
REQ-035 SHALL pass: rst asserted during byte 30 -> all outputs 0 within the same cycle; after release and a new start, a full correct sentence is sent.
REQ-036 SHALL pass: latitude input changed after start -> the transmitted latitude equals the value latched at start.
